// File: rtl/alu_exec_if.sv
`default_nettype none
// ============================================================================
// Module : alu_exec_if
// Desc   : start/busy/done request bundle between the decoder and the ALU
// Rev    : 1.0
// ============================================================================
interface alu_exec_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      ALUOp;
  logic [2:0]      funct3;
  logic            op5;
  logic            funct7b5;
  logic            funct7b0;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output start, ALUOp, funct3, op5, funct7b5, funct7b0, a, b,
    input  busy, done, result, zero, illegal
  );

  modport slave (
    input  start, ALUOp, funct3, op5, funct7b5, funct7b0, a, b,
    output busy, done, result, zero, illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module : alu_exec_unit
// Desc   : ALU decode/execute with iterative RV32M multiply/divide
// Rev    : 1.0
// ============================================================================
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter bit MEXT = 1'b1
) (
  input wire        clk,
  input wire        reset,
  alu_exec_if.slave bus
);
  localparam int c_SHW = $clog2(XLEN);
  localparam logic [c_SHW-1:0] c_LAST = c_SHW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_accept;
  logic [c_SHW-1:0]  r_cnt;
  // r_acc is the product accumulator for MUL and the partial remainder for DIV
  logic [XLEN-1:0]   r_acc;
  logic [XLEN-1:0]   r_opa;
  logic [XLEN-1:0]   r_opb;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_is_rem;
  logic [XLEN-1:0]   r_result;
  logic              r_illegal;

  logic [XLEN-1:0]   w_alu;
  logic              w_ill;
  logic              w_is_mul;
  logic              w_is_div;
  logic              w_sgn;
  logic              w_rem;
  logic [c_SHW-1:0]  w_shamt;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN-1:0]   w_acc_next;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_next;
  logic [XLEN-1:0]   w_quo_next;
  logic [XLEN-1:0]   w_div_res;

  assign w_shamt = bus.b[c_SHW-1:0];

  always_comb begin
    w_alu    = '0;
    w_ill    = 1'b0;
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    w_sgn    = 1'b0;
    w_rem    = 1'b0;
    case (bus.ALUOp)
      2'b00: w_alu = bus.a + bus.b;
      2'b01: w_alu = bus.a - bus.b;
      2'b10: begin
        if (bus.op5 && bus.funct7b0) begin
          if (!MEXT) begin
            w_ill = 1'b1;
          end else begin
            case (bus.funct3)
              3'b000:  w_is_mul = 1'b1;
              3'b100:  begin w_is_div = 1'b1; w_sgn = 1'b1; end
              3'b101:  w_is_div = 1'b1;
              3'b110:  begin w_is_div = 1'b1; w_sgn = 1'b1; w_rem = 1'b1; end
              3'b111:  begin w_is_div = 1'b1; w_rem = 1'b1; end
              default: w_ill = 1'b1;
            endcase
          end
        end else begin
          case (bus.funct3)
            3'b000:  w_alu = (bus.op5 && bus.funct7b5) ? bus.a - bus.b : bus.a + bus.b;
            3'b001:  w_alu = bus.a << w_shamt;
            3'b010:  w_alu = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            3'b011:  w_alu = {{(XLEN-1){1'b0}}, bus.a < bus.b};
            3'b100:  w_alu = bus.a ^ bus.b;
            3'b101:  w_alu = bus.funct7b5 ? $signed(bus.a) >>> w_shamt : bus.a >> w_shamt;
            3'b110:  w_alu = bus.a | bus.b;
            default: w_alu = bus.a & bus.b;
          endcase
        end
      end
      default: w_ill = 1'b1;
    endcase
  end

  assign w_a_mag = (w_sgn && bus.a[XLEN-1]) ? -bus.a : bus.a;
  assign w_b_mag = (w_sgn && bus.b[XLEN-1]) ? -bus.b : bus.b;

  // One shift-add multiply step and one restoring divide step per cycle
  assign w_acc_next = r_acc + (r_opb[0] ? r_opa : '0);
  assign w_shift    = {r_acc, r_opa[XLEN-1]};
  assign w_diff     = w_shift - {1'b0, r_opb};
  assign w_ge       = ~w_diff[XLEN];
  assign w_rem_next = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_next = {r_opa[XLEN-2:0], w_ge};
  assign w_div_res  = r_is_rem ? (r_neg_r ? -w_rem_next : w_rem_next)
                               : (r_neg_q ? -w_quo_next : w_quo_next);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          if (w_is_mul)      w_next = S_MUL;
          else if (w_is_div) w_next = S_DIV;
          else               w_next = S_DONE;
        end
      end
      S_MUL, S_DIV: if (r_cnt == c_LAST) w_next = S_DONE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_is_rem  <= 1'b0;
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_illegal <= w_ill;
      if (w_is_mul) begin
        r_opa <= bus.a;
        r_opb <= bus.b;
      end else if (w_is_div) begin
        r_opa    <= w_a_mag;
        r_opb    <= w_b_mag;
        // Division by zero keeps the all-ones quotient unsigned-looking
        r_neg_q  <= w_sgn && (bus.a[XLEN-1] ^ bus.b[XLEN-1]) && (|bus.b);
        r_neg_r  <= w_sgn && bus.a[XLEN-1];
        r_is_rem <= w_rem;
      end else begin
        r_result <= w_ill ? '0 : w_alu;
      end
    end else if (r_state == S_MUL) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_acc_next;
      r_opa <= r_opa << 1;
      r_opb <= r_opb >> 1;
      if (r_cnt == c_LAST) r_result <= w_acc_next;
    end else if (r_state == S_DIV) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_rem_next;
      r_opa <= w_quo_next;
      if (r_cnt == c_LAST) r_result <= w_div_res;
    end
  end

  assign bus.busy    = (r_state == S_MUL) || (r_state == S_DIV);
  assign bus.done    = (r_state == S_DONE);
  assign bus.result  = r_result;
  assign bus.zero    = bus.done && (r_result == '0);
  assign bus.illegal = r_illegal;
endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_exec_unit
// Desc   : scoreboard bench for alu_exec_unit (MEXT=1 and MEXT=0 instances)
// Rev    : 1.0
// ============================================================================
module tb_alu_exec_unit;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]  aluop;
  logic [2:0]  f3;
  logic        o5, f5, f0;
  logic [31:0] av, bv;
  logic        st0, st1;

  alu_exec_if #(.XLEN(XLEN)) bus0 ();
  alu_exec_if #(.XLEN(XLEN)) bus1 ();

  assign bus0.start = st0;   assign bus1.start = st1;
  assign bus0.ALUOp = aluop; assign bus1.ALUOp = aluop;
  assign bus0.funct3 = f3;   assign bus1.funct3 = f3;
  assign bus0.op5 = o5;      assign bus1.op5 = o5;
  assign bus0.funct7b5 = f5; assign bus1.funct7b5 = f5;
  assign bus0.funct7b0 = f0; assign bus1.funct7b0 = f0;
  assign bus0.a = av;        assign bus1.a = av;
  assign bus0.b = bv;        assign bus1.b = bv;

  alu_exec_unit #(.XLEN(XLEN), .MEXT(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  alu_exec_unit #(.XLEN(XLEN), .MEXT(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct {
    logic [31:0] res;
    bit          ill;
    bit          multi;
    int          t;
    int          id;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_id = 0;
  int bcnt0 = 0;
  int bcnt1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s id=%0d actual=0x%0h required=0x%0h", nm, id, act, exp);
    end
  endtask

  // Reference behaviour from the instruction semantics, using wide signed arithmetic
  function automatic void model(input logic [1:0] op, input logic [2:0] fn3,
                                input logic p5, input logic q5, input logic m0,
                                input logic [31:0] a, input logic [31:0] b, input bit mext,
                                output logic [31:0] r, output bit ill, output bit multi);
    longint      sa, sb;
    logic [63:0] t;
    logic [4:0]  sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = b[4:0];
    r = '0; ill = 1'b0; multi = 1'b0;
    if (op == 2'b00) r = a + b;
    else if (op == 2'b01) r = a - b;
    else if (op == 2'b11) ill = 1'b1;
    else if (p5 && m0) begin
      if (!mext || fn3 == 3'b001 || fn3 == 3'b010 || fn3 == 3'b011) ill = 1'b1;
      else begin
        multi = 1'b1;
        case (fn3)
          3'b000: begin t = sa * sb; r = t[31:0]; end
          3'b100: if (b == 0) r = '1; else begin t = sa / sb; r = t[31:0]; end
          3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
          3'b110: if (b == 0) r = a; else begin t = sa % sb; r = t[31:0]; end
          default: r = (b == 0) ? a : a % b;
        endcase
      end
    end else begin
      case (fn3)
        3'b000: r = (p5 && q5) ? a - b : a + b;
        3'b001: r = a << sh;
        3'b010: r = (sa < sb) ? 32'd1 : 32'd0;
        3'b011: r = (a < b) ? 32'd1 : 32'd0;
        3'b100: r = a ^ b;
        3'b101: r = q5 ? $signed(a) >>> sh : a >> sh;
        3'b110: r = a | b;
        default: r = a & b;
      endcase
    end
  endfunction

  task automatic check_done(input bit sel, input logic [31:0] res, input logic ill,
                            input logic zr, input logic bsy, input int bc);
    exp_t e;
    int   lat;
    chk("busy_during_done", -1, bsy, 0);
    if ((sel ? q1.size() : q0.size()) == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL unexpected_done dut%0d actual=done required=no_done", sel);
      return;
    end
    if (sel) e = q1.pop_front();
    else     e = q0.pop_front();
    lat = e.multi ? XLEN : 0;
    chk("result", e.id, res, e.res);
    chk("illegal", e.id, ill, e.ill);
    chk("zero", e.id, zr, (e.res == 0));
    chk("latency", e.id, cyc - e.t, lat);
    chk("busy_cycles", e.id, bc, lat);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      bcnt0 = 0;
    end else begin
      if (bus0.busy) bcnt0++;
      if (bus0.done) begin
        check_done(1'b0, bus0.result, bus0.illegal, bus0.zero, bus0.busy, bcnt0);
        bcnt0 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      bcnt1 = 0;
    end else begin
      if (bus1.busy) bcnt1++;
      if (bus1.done) begin
        check_done(1'b1, bus1.result, bus1.illegal, bus1.zero, bus1.busy, bcnt1);
        bcnt1 = 0;
      end
    end
  end

  task automatic issue(input bit sel, input logic [1:0] op, input logic [2:0] fn3,
                       input logic p5, input logic q5, input logic m0,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit push, input int hold);
    exp_t e;
    int   g = 0;
    @(negedge clk);
    while (((sel ? (bus1.busy | bus1.done) : (bus0.busy | bus0.done)) !== 1'b0) && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_wait dut%0d actual=busy required=idle", sel);
    end
    aluop = op; f3 = fn3; o5 = p5; f5 = q5; f0 = m0; av = a; bv = b;
    if (sel) st1 = 1'b1;
    else     st0 = 1'b1;
    @(posedge clk);
    #1;
    model(op, fn3, p5, q5, m0, a, b, !sel, e.res, e.ill, e.multi);
    e.t  = cyc;
    e.id = n_id;
    n_id++;
    if (push) begin
      if (sel) q1.push_back(e);
      else     q0.push_back(e);
    end
    if (hold > 0) repeat (hold) @(negedge clk);
    st0 = 1'b0;
    st1 = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((q0.size() != 0 || q1.size() != 0) && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) begin
      n_cmp++; n_bad++;
      $display("FAIL drain actual=%0d/%0d_pending required=0", q0.size(), q1.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    st0 = 1'b0; st1 = 1'b0;
    aluop = '0; f3 = '0; o5 = 1'b0; f5 = 1'b0; f0 = 1'b0; av = '0; bv = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", -1, bus0.busy, 0);
    chk("rst_done", -1, bus0.done, 0);
    chk("rst_result", -1, bus0.result, 0);
    chk("rst_zero", -1, bus0.zero, 0);
    chk("rst_illegal", -1, bus0.illegal, 0);
    chk("rst_done_m0", -1, bus1.done, 0);
    reset = 1'b0;

    issue(0, 2'b00, 3'b000, 0, 0, 0, 32'd5, 32'd7, 1, 0);
    issue(0, 2'b10, 3'b000, 1, 1, 0, 32'd3, 32'd3, 1, 0);
    issue(0, 2'b10, 3'b000, 0, 1, 0, 32'd3, 32'd3, 1, 0);
    issue(0, 2'b01, 3'b000, 0, 0, 0, 32'd3, 32'd10, 1, 0);
    issue(0, 2'b10, 3'b101, 1, 1, 0, 32'h8000_00F0, 32'd4, 1, 0);
    issue(0, 2'b10, 3'b010, 1, 0, 0, 32'hFFFF_FFFF, 32'd1, 1, 0);
    issue(0, 2'b10, 3'b011, 1, 0, 0, 32'hFFFF_FFFF, 32'd1, 1, 0);
    issue(0, 2'b10, 3'b000, 1, 0, 1, 32'hFFFF_FFFD, 32'd7, 1, 20);
    issue(0, 2'b10, 3'b100, 1, 0, 1, 32'hFFFF_FFF9, 32'd2, 1, 0);
    issue(0, 2'b10, 3'b110, 1, 0, 1, 32'hFFFF_FFF9, 32'd2, 1, 0);
    issue(0, 2'b10, 3'b101, 1, 0, 1, 32'd123, 32'd0, 1, 0);
    issue(0, 2'b10, 3'b100, 1, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    issue(0, 2'b10, 3'b110, 1, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    issue(0, 2'b10, 3'b110, 1, 0, 1, 32'hFFFF_FFFB, 32'd0, 1, 0);
    issue(0, 2'b10, 3'b111, 1, 0, 1, 32'd77, 32'd0, 1, 0);
    issue(0, 2'b10, 3'b100, 1, 0, 1, 32'd100, 32'd0, 1, 0);
    issue(0, 2'b11, 3'b000, 0, 0, 0, 32'd9, 32'd9, 1, 0);
    issue(0, 2'b10, 3'b010, 1, 0, 1, 32'd9, 32'd9, 1, 0);
    issue(1, 2'b10, 3'b000, 1, 0, 1, 32'd6, 32'd7, 1, 0);
    issue(1, 2'b10, 3'b100, 1, 0, 1, 32'd6, 32'd7, 1, 0);
    issue(1, 2'b10, 3'b000, 1, 0, 0, 32'd6, 32'd7, 1, 0);
    issue(0, 2'b00, 3'b000, 0, 0, 0, 32'd1, 32'd2, 1, 0);
    drain();

    // Reset in the middle of a divide: the operation must vanish without a done
    issue(0, 2'b10, 3'b100, 1, 0, 1, 32'hFFFF_FFF9, 32'd2, 0, 0);
    repeat (9) @(negedge clk);
    chk("busy_before_reset", -1, bus0.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midop_rst_busy", -1, bus0.busy, 0);
    chk("midop_rst_done", -1, bus0.done, 0);
    chk("midop_rst_result", -1, bus0.result, 0);
    reset = 1'b0;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] ra, rb;
      logic [1:0]  rop;
      int          k;
      ra = $urandom;
      rb = $urandom;
      k  = $urandom_range(0, 9);
      if (k == 0)      rb = '0;
      else if (k == 1) rb = '1;
      else if (k == 2) rb = 32'($urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      rop = ($urandom_range(0, 5) < 4) ? 2'b10 : 2'($urandom_range(0, 3));
      issue((i % 5) == 4, rop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb, 1, 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
